// File: rtl/clock_pkg.sv
// Mode encodings shared by the clock set controller and its users.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_SET_SEC = 2'b11
  } mode_e;

  // RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN; the 2-bit add wraps naturally.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Button front end: 2-FF synchroniser, rising-edge detect and optional auto-repeat.
module key_repeat #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic CP,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic held,
  output logic evt
);

  localparam int unsigned CntW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CntW-1:0] Delay  = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] Reload = CntW'(REPEAT_DELAY - REPEAT_RATE + 1);

  logic            sync1_q, sync2_q, prev_q;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise, fire;

  assign rise = sync2_q & ~prev_q;
  assign fire = REPEAT_EN & armed_q & sync2_q & (cnt_q == Delay);
  assign held = sync2_q;
  assign evt  = ~clr & (rise | fire);

  // Only a press seen while not cleared arms the repeat; clearing mid-hold needs a new press.
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (clr || !sync2_q) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (rise) begin
      armed_d = 1'b1;
      cnt_d   = CntW'(1);
    end else if (armed_q && REPEAT_EN) begin
      cnt_d = (cnt_q == Delay) ? Reload : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller: 1 Hz enable, mode sequencing, steered increment pulses and blink.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_unit,
  input  logic       btn_ten,
  output logic       sec_en,
  output logic       sec_inc_unit,
  output logic       sec_inc_ten,
  output logic       min_inc_unit,
  output logic       min_inc_ten,
  output logic       hr_inc_unit,
  output logic       hr_inc_ten,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] TickLast = PreW'(TICK_DIV - 1);
  localparam logic [PreW-1:0] HalfLast = PreW'(TICK_DIV / 2 - 1);

  mode_e           mode_q, mode_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            blink_q, blink_d;
  logic            sec_en_q, sec_en_d;
  logic [5:0]      inc_q, inc_d;  // {hr_ten, hr_unit, min_ten, min_unit, sec_ten, sec_unit}

  logic run, tick, half;
  logic mode_evt, unit_evt, ten_evt, unit_held;
  logic unused_held;

  assign run  = (mode_q == MODE_RUN);
  assign tick = (pre_q == TickLast);
  assign half = tick | (pre_q == HalfLast);

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (1'b0)
  ) u_key_mode (
    .CP   (CP),
    .reset(reset),
    .btn  (btn_mode),
    .clr  (1'b0),
    .held (unused_held),
    .evt  (mode_evt)
  );

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (1'b1)
  ) u_key_unit (
    .CP   (CP),
    .reset(reset),
    .btn  (btn_unit),
    .clr  (run | mode_evt),
    .held (unit_held),
    .evt  (unit_evt)
  );

  // A held unit button locks out the ten path entirely.
  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (1'b1)
  ) u_key_ten (
    .CP   (CP),
    .reset(reset),
    .btn  (btn_ten),
    .clr  (run | mode_evt | unit_held),
    .held (),
    .evt  (ten_evt)
  );

  always_comb begin
    mode_d   = mode_evt ? next_mode(mode_q) : mode_q;
    pre_d    = (mode_evt || tick) ? '0 : pre_q + PreW'(1);
    sec_en_d = run & tick & ~mode_evt;

    blink_d = blink_q;
    if (mode_evt) begin
      blink_d = (mode_d != MODE_RUN);
    end else if (run) begin
      blink_d = 1'b0;
    end else if (half) begin
      blink_d = ~blink_q;
    end

    inc_d = '0;
    unique case (mode_q)
      MODE_SET_HR:  inc_d = {ten_evt, unit_evt, 4'b0000};
      MODE_SET_MIN: inc_d = {2'b00, ten_evt, unit_evt, 2'b00};
      MODE_SET_SEC: inc_d = {4'b0000, ten_evt, unit_evt};
      default:      inc_d = '0;
    endcase
  end

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE_RUN;
      pre_q    <= '0;
      blink_q  <= 1'b0;
      sec_en_q <= 1'b0;
      inc_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      blink_q  <= blink_d;
      sec_en_q <= sec_en_d;
      inc_q    <= inc_d;
    end
  end

  assign mode         = mode_q;
  assign blink        = blink_q;
  assign sec_en       = sec_en_q;
  assign sec_inc_unit = inc_q[0];
  assign sec_inc_ten  = inc_q[1];
  assign min_inc_unit = inc_q[2];
  assign min_inc_ten  = inc_q[3];
  assign hr_inc_unit  = inc_q[4];
  assign hr_inc_ten   = inc_q[5];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed plan plus random buttons against a cycle model.
module tb_clock_set_ctrl;

  localparam int T = 10;
  localparam int D = 20;
  localparam int R = 5;

  logic       CP = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_unit = 1'b0, btn_ten = 1'b0;
  logic       sec_en, sec_inc_unit, sec_inc_ten, min_inc_unit, min_inc_ten;
  logic       hr_inc_unit, hr_inc_ten, blink;
  logic [1:0] mode;

  always #5 CP = ~CP;

  clock_set_ctrl #(
    .TICK_DIV    (T),
    .REPEAT_DELAY(D),
    .REPEAT_RATE (R)
  ) dut (
    .CP          (CP),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_unit    (btn_unit),
    .btn_ten     (btn_ten),
    .sec_en      (sec_en),
    .sec_inc_unit(sec_inc_unit),
    .sec_inc_ten (sec_inc_ten),
    .min_inc_unit(min_inc_unit),
    .min_inc_ten (min_inc_ten),
    .hr_inc_unit (hr_inc_unit),
    .hr_inc_ten  (hr_inc_ten),
    .mode        (mode),
    .blink       (blink)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: buttons indexed 0 mode, 1 unit, 2 ten. age = cycles held since an accepted press, -1 if none.
  bit         dly1[3], lvl[3], plvl[3];
  int         age[3];
  int         m_mode, ph;
  bit         m_blink;
  logic [9:0] exp_out;

  int sec_en_t[$], hr_ten_t[$], min_u_t[$];
  int cnt_sec_u, cnt_inc;

  function automatic logic [5:0] incs();
    return {hr_inc_ten, hr_inc_unit, min_inc_ten, min_inc_unit, sec_inc_ten, sec_inc_unit};
  endfunction

  function automatic logic [9:0] obs();
    return {mode, blink, sec_en, incs()};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      dly1[i] = 0; lvl[i] = 0; plvl[i] = 0; age[i] = -1;
    end
    m_mode = 0; ph = 0; m_blink = 0;
  endtask

  task automatic key_model(input int b, input bit clr, output bit ev);
    ev = 0;
    if (clr || !lvl[b]) age[b] = -1;
    else if (!plvl[b]) begin
      age[b] = 0; ev = 1;
    end else if (age[b] >= 0) begin
      age[b]++;
      ev = (age[b] >= D) && ((age[b] - D) % R == 0);
    end
  endtask

  task automatic model_edge(input bit bm, input bit bu, input bit bt);
    bit mev, ev_u, ev_t, tick, half;
    int nm;
    logic [5:0] inc;
    mev = lvl[0] && !plvl[0];
    key_model(1, (m_mode == 0) || mev, ev_u);
    key_model(2, (m_mode == 0) || mev || lvl[1], ev_t);
    nm   = mev ? (m_mode + 1) % 4 : m_mode;
    tick = (ph % T) == T - 1;
    half = tick || ((ph % T) == T / 2 - 1);
    inc  = '0;
    if (m_mode != 0) begin
      inc[(3 - m_mode) * 2]     = ev_u;
      inc[(3 - m_mode) * 2 + 1] = ev_t;
    end
    if (mev) m_blink = (nm != 0);
    else if (m_mode == 0) m_blink = 0;
    else if (half) m_blink = !m_blink;
    exp_out = {nm[1:0], m_blink, (m_mode == 0) && !mev && tick, inc};
    ph      = mev ? 0 : ph + 1;
    m_mode  = nm;
    for (int i = 0; i < 3; i++) begin
      plvl[i] = lvl[i];
      lvl[i]  = dly1[i];
    end
    dly1[0] = bm; dly1[1] = bu; dly1[2] = bt;
  endtask

  task automatic step(input bit bm, input bit bu, input bit bt);
    btn_mode = bm; btn_unit = bu; btn_ten = bt;
    @(posedge CP);
    #1;
    cyc++;
    model_edge(bm, bu, bt);
    check($sformatf("outputs@%0d", cyc), obs(), exp_out);
    check($sformatf("exclusive@%0d", cyc),
          ($countones(incs()) <= 1) && !(sec_en && (sec_inc_unit || sec_inc_ten)), 1);
    if (sec_en) sec_en_t.push_back(cyc);
    if (hr_inc_ten) hr_ten_t.push_back(cyc);
    if (min_inc_unit) min_u_t.push_back(cyc);
    cnt_sec_u += sec_inc_unit;
    cnt_inc   += $countones(incs());
  endtask

  task automatic press_mode();
    repeat (5) step(1, 0, 0);
    repeat (12) step(0, 0, 0);
  endtask

  initial begin
    int exp_t[5];
    int exp_mode[4];
    int t0;
    bit rm, ru, rt;
    exp_t = '{3, 23, 28, 33, 38};
    exp_mode = '{1, 2, 3, 0};

    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge CP);
    #1;
    check("reset_outputs", obs(), 0);
    reset = 1'b1;

    repeat (35) step(0, 0, 0);
    check("sec_en_count", sec_en_t.size(), 3);
    if (sec_en_t.size() == 3) begin
      check("sec_en_first", sec_en_t[0], 10);
      check("sec_en_gap1", sec_en_t[1] - sec_en_t[0], 10);
      check("sec_en_gap2", sec_en_t[2] - sec_en_t[1], 10);
    end
    check("run_no_inc", cnt_inc, 0);

    // Prescaler is now at 6; reset mid-count.
    step(0, 0, 0);
    reset = 1'b0;
    #1;
    check("reset_mid_outputs", obs(), 0);
    @(posedge CP);
    #1;
    reset = 1'b1;
    model_reset();
    cyc = 0;
    sec_en_t.delete();
    repeat (12) step(0, 0, 0);
    check("sec_en_after_reset_count", sec_en_t.size(), 1);
    if (sec_en_t.size() == 1) check("sec_en_after_reset_time", sec_en_t[0], 10);

    for (int i = 0; i < 4; i++) begin
      press_mode();
      check($sformatf("mode_press_%0d", i + 1), mode, exp_mode[i]);
      if (i == 0) sec_en_t.delete();
      if (i == 2) check("sec_en_in_set", sec_en_t.size(), 0);
    end

    press_mode();
    press_mode();
    check("mode_set_min", mode, 2);
    cnt_inc = 0;
    min_u_t.delete();
    t0 = cyc + 1;
    step(0, 1, 0);
    repeat (8) step(0, 0, 0);
    check("min_unit_count", min_u_t.size(), 1);
    check("min_only_inc", cnt_inc, 1);
    if (min_u_t.size() == 1) check("min_unit_latency", min_u_t[0] - t0 + 1, 3);

    repeat (3) press_mode();
    check("mode_set_hr", mode, 1);
    hr_ten_t.delete();
    t0 = cyc + 1;
    repeat (40) step(0, 0, 1);
    repeat (15) step(0, 0, 0);
    check("hr_ten_count", hr_ten_t.size(), 5);
    if (hr_ten_t.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("hr_ten_t%0d", i), hr_ten_t[i] - t0 + 1, exp_t[i]);
    end

    press_mode();
    press_mode();
    check("mode_set_sec", mode, 3);
    cnt_sec_u = 0;
    repeat (5) step(1, 1, 0);
    repeat (5) step(0, 0, 0);
    check("mode_wins_mode", mode, 0);
    check("mode_wins_no_inc", cnt_sec_u, 0);
    cnt_inc = 0;
    repeat (30) step(0, 1, 1);
    repeat (5) step(0, 0, 0);
    check("run_ignores_buttons", cnt_inc, 0);

    rm = 0; ru = 0; rt = 0;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) rm = !rm;
      if ($urandom_range(0, 29) == 0) ru = !ru;
      if ($urandom_range(0, 29) == 0) rt = !rt;
      step(rm, ru, rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
